// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter that drives the one-hot select of a shared 3-input mux.
// A grant is held until the owner signals done, drops its request, or hits the hold limit.
module mux3_rr_arbiter #(
  parameter int MAX_HOLD  = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] iReq,
  input  logic [2:0] iDone,
  output logic [2:0] oSelect,
  output logic [1:0] oOwner,
  output logic       oBusy,
  output logic       oTimeout,
  output logic [1:0] oTimeoutId
);

  typedef enum logic {ST_IDLE, ST_OWN} state_e;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 to_q, to_d;
  logic [1:0]           to_id_q, to_id_d;

  logic [2:0] pick;
  logic [2:0] mask;
  logic       done_k, drop_k, hit_max;

  function automatic logic [2:0] one_hot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Returns {found, index}; search order is last+1, last+2, last (mod 3).
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] c1, c2;
    c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (req[c1])        return {1'b1, c1};
    else if (req[c2])   return {1'b1, c2};
    else if (req[last]) return {1'b1, last};
    else                return 3'b000;
  endfunction

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    to_id_d = 2'd0;
    pick    = 3'b000;
    mask    = iReq;
    done_k  = 1'b0;
    drop_k  = 1'b0;
    hit_max = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pick = rr_pick(last_q, iReq);
        if (pick[2]) begin
          state_d = ST_OWN;
          owner_d = pick[1:0];
          sel_d   = one_hot(pick[1:0]);
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        done_k  = iDone[owner_q];
        drop_k  = !iReq[owner_q];
        hit_max = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
        if (done_k || drop_k || hit_max) begin
          last_d = owner_q;
          cnt_d  = '0;
          mask   = iReq & ~one_hot(owner_q);
          // A finishing owner may keep the resource only when nobody else wants it.
          if (done_k && iReq[owner_q] && (mask == 3'b000)) mask = iReq;
          to_d    = hit_max && !done_k && !drop_k;
          to_id_d = to_d ? owner_q : 2'd0;
          pick    = rr_pick(owner_q, mask);
          if (pick[2]) begin
            owner_d = pick[1:0];
            sel_d   = one_hot(pick[1:0]);
          end else begin
            state_d = ST_IDLE;
            owner_d = 2'd0;
            sel_d   = 3'b000;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
        sel_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'b000;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      to_id_q <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      to_id_q <= to_id_d;
    end
  end

  assign oSelect    = sel_q;
  assign oOwner     = owner_q;
  assign oBusy      = (state_q == ST_OWN);
  assign oTimeout   = to_q;
  assign oTimeoutId = to_id_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter (hold limit 4): the driver queues the expected
// registered outputs for each cycle and a monitor compares them one cycle later.
module tb_mux3_rr_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] done = 3'b000;
  logic [2:0] sel;
  logic [1:0] owner;
  logic       busy;
  logic       tout;
  logic [1:0] tid;
  logic [8:0] act;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  mux3_rr_arbiter #(.MAX_HOLD(4), .CNT_WIDTH(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .iReq       (req),
    .iDone      (done),
    .oSelect    (sel),
    .oOwner     (owner),
    .oBusy      (busy),
    .oTimeout   (tout),
    .oTimeoutId (tid)
  );

  always #5 clk = ~clk;

  assign act = {sel, owner, busy, tout, tid};

  function automatic logic [8:0] pack_exp(input logic [2:0] s, input logic t, input logic [1:0] id);
    logic [1:0] o;
    case (s)
      3'b010:  o = 2'd1;
      3'b100:  o = 2'd2;
      default: o = 2'd0;
    endcase
    return {s, o, (s != 3'b000), t, id};
  endfunction

  task automatic check(input string name, input logic [8:0] a, input logic [8:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got sel=%b owner=%0d busy=%b to=%b id=%0d, want sel=%b owner=%0d busy=%b to=%b id=%0d",
               name, a[8:6], a[5:4], a[3], a[2], a[1:0], e[8:6], e[5:4], e[3], e[2], e[1:0]);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check(tag_q.pop_front(), act, exp_q.pop_front());
  end

  task automatic step(input string tag, input logic [2:0] r, input logic [2:0] d,
                      input logic [2:0] s, input logic t, input logic [1:0] id);
    @(negedge clk);
    req  = r;
    done = d;
    exp_q.push_back(pack_exp(s, t, id));
    tag_q.push_back(tag);
    @(posedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn = 1'b0;
    req  = 3'b000;
    done = 3'b000;
    #1 check({tag, "_now"}, act, 9'd0);
    repeat (2) @(posedge clk);
    #1 check({tag, "_held"}, act, 9'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset");

    // Single requester, done on its 4th grant cycle (coincides with hold limit: done wins).
    step("solo_g1", 3'b001, 3'b000, 3'b001, 1'b0, 2'd0);
    step("solo_g2", 3'b001, 3'b000, 3'b001, 1'b0, 2'd0);
    step("solo_g3", 3'b001, 3'b000, 3'b001, 1'b0, 2'd0);
    step("solo_g4", 3'b001, 3'b000, 3'b001, 1'b0, 2'd0);
    step("solo_done", 3'b000, 3'b001, 3'b000, 1'b0, 2'd0);
    step("solo_idle", 3'b000, 3'b000, 3'b000, 1'b0, 2'd0);

    // All requesting, owner finishes every cycle: rotation without bubbles.
    do_reset("reset2");
    step("rr_first", 3'b111, 3'b000, 3'b001, 1'b0, 2'd0);
    step("rr_to1", 3'b111, 3'b001, 3'b010, 1'b0, 2'd0);
    step("rr_to2", 3'b111, 3'b010, 3'b100, 1'b0, 2'd0);
    step("rr_to0", 3'b111, 3'b100, 3'b001, 1'b0, 2'd0);
    step("rr_to1b", 3'b111, 3'b001, 3'b010, 1'b0, 2'd0);
    step("rr_idle", 3'b000, 3'b000, 3'b000, 1'b0, 2'd0);

    // Owner 1 withdraws while 2 waits: direct handoff.
    step("wd_g1", 3'b010, 3'b000, 3'b010, 1'b0, 2'd0);
    step("wd_hold", 3'b110, 3'b000, 3'b010, 1'b0, 2'd0);
    step("wd_hand", 3'b100, 3'b000, 3'b100, 1'b0, 2'd0);
    step("wd_idle", 3'b000, 3'b000, 3'b000, 1'b0, 2'd0);

    // Hold limit: each owner keeps the grant 4 cycles, then is revoked.
    step("to_g0a", 3'b011, 3'b000, 3'b001, 1'b0, 2'd0);
    step("to_g0b", 3'b011, 3'b000, 3'b001, 1'b0, 2'd0);
    step("to_g0c", 3'b011, 3'b000, 3'b001, 1'b0, 2'd0);
    step("to_g0d", 3'b011, 3'b000, 3'b001, 1'b0, 2'd0);
    step("to_rev0", 3'b011, 3'b000, 3'b010, 1'b1, 2'd0);
    step("to_g1b", 3'b011, 3'b000, 3'b010, 1'b0, 2'd0);
    step("to_g1c", 3'b011, 3'b000, 3'b010, 1'b0, 2'd0);
    step("to_g1d", 3'b011, 3'b000, 3'b010, 1'b0, 2'd0);
    step("to_rev1", 3'b011, 3'b000, 3'b001, 1'b1, 2'd1);
    step("to_idle", 3'b000, 3'b000, 3'b000, 1'b0, 2'd0);

    // Sole requester finishing every cycle keeps the grant; foreign done bits ignored.
    step("keep_g", 3'b010, 3'b000, 3'b010, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) step("keep_done", 3'b010, 3'b010, 3'b010, 1'b0, 2'd0);
    step("keep_foreign", 3'b010, 3'b101, 3'b010, 1'b0, 2'd0);
    step("keep_idle", 3'b000, 3'b000, 3'b000, 1'b0, 2'd0);

    // Done on the limit edge with no competitor: re-grant, no timeout pulse.
    step("lim_g1", 3'b100, 3'b000, 3'b100, 1'b0, 2'd0);
    step("lim_g2", 3'b100, 3'b000, 3'b100, 1'b0, 2'd0);
    step("lim_g3", 3'b100, 3'b000, 3'b100, 1'b0, 2'd0);
    step("lim_g4", 3'b100, 3'b000, 3'b100, 1'b0, 2'd0);
    step("lim_done", 3'b100, 3'b100, 3'b100, 1'b0, 2'd0);
    step("lim_after", 3'b100, 3'b000, 3'b100, 1'b0, 2'd0);

    // Asynchronous reset in the middle of a grant.
    #3;
    rstn = 1'b0;
    req  = 3'b000;
    done = 3'b000;
    #1 check("async_reset", act, 9'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step("post_reset", 3'b111, 3'b000, 3'b001, 1'b0, 2'd0);
    step("post_idle", 3'b000, 3'b000, 3'b000, 1'b0, 2'd0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
